scan_dump_ctrl: RTL and testbench
=================================

# scan_dump_ctrl

Multi-chain scan-unload controller that replaces the single-channel, fixed-length DFT dump path between the AXI pre-wrapper's DFT interface and the design under test. On a DFT operation request it drives scan enable, unloads up to 16 scan chains of configurable length in parallel, and packs each chain's bits into 32-bit words. It streams those words to the pre-wrapper one strobe at a time, repeats for a configurable number of dumps, then runs the commit handshake. Optional recirculation restores chain contents after each dump so the DUT state survives inspection.

## Interface
- P_NBR_CHAINS, 1: number of scan chains, 1..16.
- P_CHAIN_LEN, 32: bits per chain, 1..1024; need not be a multiple of 32.
- P_DUMP_NBR, 27'd1: full unloads per operation, ≥1.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; returns everything to IDLE.
- recirc_en  in  1  1 = scan_in mirrors scan_out (non-destructive dump); sampled at op start.
- scan_out  in  P_NBR_CHAINS  serial outputs of the chains, bit i = chain i.
- scan_in  out  P_NBR_CHAINS  serial inputs to the chains.
- ex_sen  out  1  scan enable to the DUT.
- dft_val_op  in  1  operation request from the pre-wrapper.
- dft_op_ack  out  1  one-cycle acceptance pulse.
- dft_output_data  out  32  packed dump word.
- dft_output_strobe  out  1  one-cycle pulse, dft_output_data valid.
- dft_op_commit  out  1  operation complete, held until acknowledged.
- dft_commit_ack  in  1  pre-wrapper commit acknowledge.

## Operation
- Words per chain W = ceil(P_CHAIN_LEN/32); words per dump = P_NBR_CHAINS·W.
- States: IDLE, ACK, SHIFT, EMIT, COMMIT.
- IDLE: dft_val_op=1 → ACK; latch recirc_en; clear bit counter, dump counter, word buffers.
- ACK: dft_op_ack=1 for exactly this cycle → SHIFT.
- SHIFT: ex_sen=1; each cycle bit b (0..31) of the current word of chain i ← scan_out[i], where b = bit counter mod 32; the first bit unloaded lands in bit 0. After 32 bits, or after the last bit of the chain → EMIT.
- EMIT: ex_sen=0 (shift paused); emit one word per cycle, chain 0 first through chain P_NBR_CHAINS-1, dft_output_strobe=1 on each. Partial final word: unused upper bits are 0. Then: more bits remain in the dump → SHIFT (buffers cleared); dump complete and dump counter < P_DUMP_NBR → SHIFT for the next dump; otherwise → COMMIT.
- COMMIT: dft_op_commit=1 until dft_commit_ack is sampled high, then IDLE next cycle.
- scan_in = recirc latched ? scan_out : 0 (combinational, all states).
- dft_val_op is ignored outside IDLE; a request held high through COMMIT starts a new operation only after a cycle spent in IDLE.
- dft_commit_ack outside COMMIT is ignored.

## Timing
- Reset values: ex_sen=0, dft_op_ack=0, dft_output_strobe=0, dft_op_commit=0, dft_output_data=0, state IDLE. Reset takes effect asynchronously and aborts any operation; ex_sen drops in the same cycle. A partial dump is discarded.
- dft_val_op sampled high at edge 0 → dft_op_ack high during cycle 1 → ex_sen high in cycles 2..(1+min(32,L)), where L = remaining bits.
- ex_sen high for exactly P_CHAIN_LEN cycles per dump, in bursts of ≤32.
- Total cycles from request to first dft_op_commit = 2 + P_DUMP_NBR·(P_CHAIN_LEN + P_NBR_CHAINS·W).
- dft_output_data holds the last emitted word between strobes.
- dft_commit_ack arriving in the same cycle that COMMIT is entered counts; the next state is IDLE.

## Test plan
- P_NBR_CHAINS=1, P_CHAIN_LEN=32, P_DUMP_NBR=1; chain holds 0xA5A5_0F0F with LSB unloaded first → ack at cycle 1, ex_sen cycles 2..33, strobe cycle 34 with data 0xA5A5_0F0F, commit at cycle 35, IDLE one cycle after ack.
- P_NBR_CHAINS=4, P_CHAIN_LEN=40, chains hold distinct patterns → 8 strobes in order: ch0..ch3 bits 0..31, then ch0..ch3 bits 32..39 with bits 31..8 = 0; ex_sen pattern is 32 on, 4 off, 8 on.
- P_DUMP_NBR=3, recirc_en=1, P_CHAIN_LEN=32 → three identical words; chain content is unchanged after commit. Repeat with recirc_en=0 → words 2 and 3 = 0.
- Assert reset mid-SHIFT at bit 17 → ex_sen and all outputs 0 immediately; a new request after release runs a full, clean dump.
- Hold dft_val_op high continuously and delay dft_commit_ack by 5 cycles → dft_op_commit is held for 6 cycles; exactly one ack per operation; the second op_ack comes no earlier than 2 cycles after commit_ack.
- Assert dft_commit_ack in IDLE and during SHIFT → no state change, and no spurious commit.

Source files
------------

// File: rtl/scan_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_dump_ctrl
// Purpose  : Multi-chain scan unload controller; packs chain bits into 32-bit
//            words and streams them to the pre-wrapper DFT interface.
// Revision : 1.0 - initial release
// ============================================================================
module scan_dump_ctrl #(
  parameter int          P_NBR_CHAINS = 1,
  parameter int          P_CHAIN_LEN  = 32,
  parameter logic [26:0] P_DUMP_NBR   = 27'd1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    recirc_en,
  input  logic [P_NBR_CHAINS-1:0] scan_out,
  output logic [P_NBR_CHAINS-1:0] scan_in,
  output logic                    ex_sen,
  input  logic                    dft_val_op,
  output logic                    dft_op_ack,
  output logic [31:0]             dft_output_data,
  output logic                    dft_output_strobe,
  output logic                    dft_op_commit,
  input  logic                    dft_commit_ack
);

  localparam int                 c_IDX_W    = (P_NBR_CHAINS > 1) ? $clog2(P_NBR_CHAINS) : 1;
  localparam logic [10:0]        c_LEN      = 11'(P_CHAIN_LEN);
  localparam logic [10:0]        c_LAST_BIT = 11'(P_CHAIN_LEN - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_CH  = c_IDX_W'(P_NBR_CHAINS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACK    = 3'd1,
    S_SHIFT  = 3'd2,
    S_EMIT   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_recirc;
  logic [10:0]          r_bit_cnt;
  logic [26:0]          r_dump_cnt;
  logic [c_IDX_W-1:0]   r_ch_idx;
  logic [31:0]          r_word_buf [P_NBR_CHAINS];
  logic [31:0]          r_last_data;
  logic [31:0]          w_emit_word;
  logic                 w_word_end;
  logic                 w_emit_last;
  logic                 w_dump_end;
  logic                 w_more_dumps;

  // r_bit_cnt is the index of the bit being captured this SHIFT cycle
  assign w_word_end   = (r_bit_cnt[4:0] == 5'd31) || (r_bit_cnt == c_LAST_BIT);
  assign w_emit_last  = (r_ch_idx == c_LAST_CH);
  assign w_dump_end   = (r_bit_cnt == c_LEN);
  assign w_more_dumps = ((r_dump_cnt + 27'd1) < P_DUMP_NBR);

  assign scan_in = r_recirc ? scan_out : '0;

  always_comb begin
    w_emit_word = '0;
    for (int i = 0; i < P_NBR_CHAINS; i++) begin
      if (r_ch_idx == c_IDX_W'(i)) begin
        w_emit_word = r_word_buf[i];
      end
    end
  end

  // Word is valid in the same cycle as its strobe, then held afterwards
  assign dft_output_data = (r_state == S_EMIT) ? w_emit_word : r_last_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    ex_sen            = 1'b0;
    dft_op_ack        = 1'b0;
    dft_output_strobe = 1'b0;
    dft_op_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dft_val_op) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        dft_op_ack  = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        ex_sen = 1'b1;
        if (w_word_end) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        dft_output_strobe = 1'b1;
        if (w_emit_last) begin
          w_state_nxt = (w_dump_end && !w_more_dumps) ? S_COMMIT : S_SHIFT;
        end
      end
      S_COMMIT: begin
        dft_op_commit = 1'b1;
        if (dft_commit_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_recirc    <= 1'b0;
      r_bit_cnt   <= '0;
      r_dump_cnt  <= '0;
      r_ch_idx    <= '0;
      r_last_data <= '0;
      for (int i = 0; i < P_NBR_CHAINS; i++) begin
        r_word_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dft_val_op) begin
            r_recirc   <= recirc_en;
            r_bit_cnt  <= '0;
            r_dump_cnt <= '0;
            r_ch_idx   <= '0;
            for (int i = 0; i < P_NBR_CHAINS; i++) begin
              r_word_buf[i] <= '0;
            end
          end
        end
        S_SHIFT: begin
          for (int i = 0; i < P_NBR_CHAINS; i++) begin
            r_word_buf[i][r_bit_cnt[4:0]] <= scan_out[i];
          end
          r_bit_cnt <= r_bit_cnt + 11'd1;
        end
        S_EMIT: begin
          r_last_data <= w_emit_word;
          if (w_emit_last) begin
            // Clearing keeps the unused upper bits of a partial word at zero
            r_ch_idx <= '0;
            for (int i = 0; i < P_NBR_CHAINS; i++) begin
              r_word_buf[i] <= '0;
            end
            if (w_dump_end) begin
              r_bit_cnt  <= '0;
              r_dump_cnt <= r_dump_cnt + 27'd1;
            end
          end else begin
            r_ch_idx <= r_ch_idx + c_IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_dump_ctrl
// Purpose  : Directed self-checking bench for scan_dump_ctrl (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] sel;
  logic       val;
  logic       cack;
  logic       recirc;

  // Instance A: 1 chain x 32 bits, 1 dump
  logic [0:0]  so_a, si_a;
  logic        sen_a, ack_a, stb_a, cmt_a, val_a;
  logic [31:0] data_a, ch_a, ld_val_a;
  logic        ld_a;
  assign so_a[0] = ch_a[0];
  assign val_a   = val && (sel == 2'd0);
  always @(posedge clk) begin
    if (ld_a) ch_a <= ld_val_a;
    else if (sen_a) ch_a <= {si_a[0], ch_a[31:1]};
  end

  scan_dump_ctrl #(.P_NBR_CHAINS(1), .P_CHAIN_LEN(32), .P_DUMP_NBR(27'd1)) u_dut_a (
    .clk(clk), .reset(reset), .recirc_en(recirc), .scan_out(so_a), .scan_in(si_a),
    .ex_sen(sen_a), .dft_val_op(val_a), .dft_op_ack(ack_a), .dft_output_data(data_a),
    .dft_output_strobe(stb_a), .dft_op_commit(cmt_a), .dft_commit_ack(cack)
  );

  // Instance B: 4 chains x 40 bits, 1 dump
  logic [3:0]  so_b, si_b;
  logic        sen_b, ack_b, stb_b, cmt_b, val_b;
  logic [31:0] data_b;
  logic [39:0] ch_b [4];
  logic        ld_b;
  assign val_b = val && (sel == 2'd1);

  function automatic logic [39:0] pat_b(input int i);
    case (i)
      0:       return 40'hAB_1234_5678;
      1:       return 40'h5C_DEAD_BEEF;
      2:       return 40'h01_8000_0001;
      default: return 40'hFF_0F0F_F0F0;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_chain_b
    assign so_b[g] = ch_b[g][0];
    always @(posedge clk) begin
      if (ld_b) ch_b[g] <= pat_b(g);
      else if (sen_b) ch_b[g] <= {si_b[g], ch_b[g][39:1]};
    end
  end

  scan_dump_ctrl #(.P_NBR_CHAINS(4), .P_CHAIN_LEN(40), .P_DUMP_NBR(27'd1)) u_dut_b (
    .clk(clk), .reset(reset), .recirc_en(recirc), .scan_out(so_b), .scan_in(si_b),
    .ex_sen(sen_b), .dft_val_op(val_b), .dft_op_ack(ack_b), .dft_output_data(data_b),
    .dft_output_strobe(stb_b), .dft_op_commit(cmt_b), .dft_commit_ack(cack)
  );

  // Instance C: 1 chain x 32 bits, 3 dumps
  logic [0:0]  so_c, si_c;
  logic        sen_c, ack_c, stb_c, cmt_c, val_c;
  logic [31:0] data_c, ch_c, ld_val_c;
  logic        ld_c;
  assign so_c[0] = ch_c[0];
  assign val_c   = val && (sel == 2'd2);
  always @(posedge clk) begin
    if (ld_c) ch_c <= ld_val_c;
    else if (sen_c) ch_c <= {si_c[0], ch_c[31:1]};
  end

  scan_dump_ctrl #(.P_NBR_CHAINS(1), .P_CHAIN_LEN(32), .P_DUMP_NBR(27'd3)) u_dut_c (
    .clk(clk), .reset(reset), .recirc_en(recirc), .scan_out(so_c), .scan_in(si_c),
    .ex_sen(sen_c), .dft_val_op(val_c), .dft_op_ack(ack_c), .dft_output_data(data_c),
    .dft_output_strobe(stb_c), .dft_op_commit(cmt_c), .dft_commit_ack(cack)
  );

  logic        obs_sen, obs_ack, obs_stb, obs_cmt;
  logic [31:0] obs_data;
  assign obs_sen  = (sel == 2'd0) ? sen_a  : (sel == 2'd1) ? sen_b  : sen_c;
  assign obs_ack  = (sel == 2'd0) ? ack_a  : (sel == 2'd1) ? ack_b  : ack_c;
  assign obs_stb  = (sel == 2'd0) ? stb_a  : (sel == 2'd1) ? stb_b  : stb_c;
  assign obs_cmt  = (sel == 2'd0) ? cmt_a  : (sel == 2'd1) ? cmt_b  : cmt_c;
  assign obs_data = (sel == 2'd0) ? data_a : (sel == 2'd1) ? data_b : data_c;

  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc, ack_cnt, ack_cyc, sen_cnt, stb_cyc, cmt_cyc, cmt_len;
  logic [127:0] sen_vec;
  logic [31:0]  words [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    ack_cnt = 0; ack_cyc = 0; sen_cnt = 0; stb_cyc = 0;
    cmt_cyc = 0; cmt_len = 0; sen_vec = '0;
    words.delete();
  endtask

  // Record per-cycle activity until commit, then acknowledge after 'delay' cycles
  task automatic wait_done(input int delay);
    int lim;
    lim = cyc + 2000;
    while (!obs_cmt && cyc < lim) begin
      if (obs_ack) begin ack_cnt++; ack_cyc = cyc; end
      if (obs_sen) begin sen_cnt++; if (cyc < 128) sen_vec[cyc] = 1'b1; end
      if (obs_stb) begin if (stb_cyc == 0) stb_cyc = cyc; words.push_back(obs_data); end
      @(negedge clk); cyc++;
    end
    check("commit_reached", {63'd0, obs_cmt}, 64'd1);
    cmt_cyc = cyc;
    cmt_len = 1;
    repeat (delay) begin
      @(negedge clk); cyc++;
      if (obs_cmt) cmt_len++;
    end
    cack = 1'b1;
    @(negedge clk); cyc++;
    cack = 1'b0;
  endtask

  task automatic run_op(input int delay, input bit hold);
    clear_rec();
    val = 1'b1;
    @(negedge clk); cyc = 1;
    if (!hold) val = 1'b0;
    wait_done(delay);
  endtask

  task automatic load_a(input logic [31:0] v);
    ld_val_a = v; ld_a = 1'b1; @(negedge clk); ld_a = 1'b0;
  endtask

  task automatic load_c(input logic [31:0] v);
    ld_val_c = v; ld_c = 1'b1; @(negedge clk); ld_c = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; val = 1'b0; cack = 1'b0; recirc = 1'b0; sel = 2'd0;
    ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0; ld_val_a = '0; ld_val_c = '0;
    repeat (3) @(negedge clk);
    check("rst_sen",    {63'd0, sen_a}, 64'd0);
    check("rst_ack",    {63'd0, ack_a}, 64'd0);
    check("rst_stb",    {63'd0, stb_b}, 64'd0);
    check("rst_commit", {63'd0, cmt_c}, 64'd0);
    check("rst_data",   {32'd0, data_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single chain, single dump
    sel = 2'd0;
    load_a(32'hA5A5_0F0F);
    run_op(0, 1'b0);
    check("t1_ack_cyc",  ack_cyc, 1);
    check("t1_ack_cnt",  ack_cnt, 1);
    check("t1_sen_vec",  sen_vec[63:0], 64'h0000_0003_FFFF_FFFC);
    check("t1_stb_cyc",  stb_cyc, 34);
    check("t1_nwords",   words.size(), 1);
    check("t1_word0",    words[0], 32'hA5A5_0F0F);
    check("t1_cmt_cyc",  cmt_cyc, 35);
    check("t1_idle",     {63'd0, obs_cmt}, 64'd0);
    check("t1_data_hold", obs_data, 32'hA5A5_0F0F);

    // Four chains, 40 bits: two word groups, partial second word
    sel = 2'd1;
    ld_b = 1'b1; @(negedge clk); ld_b = 1'b0;
    run_op(0, 1'b0);
    check("t2_sen_vec", sen_vec[63:0], 64'h0000_3FC3_FFFF_FFFC);
    check("t2_sen_cnt", sen_cnt, 40);
    check("t2_nwords",  words.size(), 8);
    check("t2_w0", words[0], 32'h1234_5678);
    check("t2_w1", words[1], 32'hDEAD_BEEF);
    check("t2_w2", words[2], 32'h8000_0001);
    check("t2_w3", words[3], 32'h0F0F_F0F0);
    check("t2_w4", words[4], 32'h0000_00AB);
    check("t2_w5", words[5], 32'h0000_005C);
    check("t2_w6", words[6], 32'h0000_0001);
    check("t2_w7", words[7], 32'h0000_00FF);
    check("t2_cmt_cyc", cmt_cyc, 50);

    // Three dumps with recirculation, then without
    sel = 2'd2;
    recirc = 1'b1;
    load_c(32'h3C96_E1D2);
    run_op(0, 1'b0);
    recirc = 1'b0;
    check("t3r_nwords",  words.size(), 3);
    check("t3r_w0",      words[0], 32'h3C96_E1D2);
    check("t3r_w1",      words[1], 32'h3C96_E1D2);
    check("t3r_w2",      words[2], 32'h3C96_E1D2);
    check("t3r_sen_cnt", sen_cnt, 96);
    check("t3r_cmt_cyc", cmt_cyc, 101);
    check("t3r_chain",   ch_c, 32'h3C96_E1D2);
    load_c(32'h3C96_E1D2);
    run_op(0, 1'b0);
    check("t3n_nwords", words.size(), 3);
    check("t3n_w0",     words[0], 32'h3C96_E1D2);
    check("t3n_w1",     words[1], 32'h0);
    check("t3n_w2",     words[2], 32'h0);
    check("t3n_chain",  ch_c, 32'h0);

    // Reset asserted while bit 17 is on scan_out
    sel = 2'd0;
    load_a(32'hFFFF_FFFF);
    val = 1'b1;
    @(negedge clk); val = 1'b0;
    repeat (18) @(negedge clk);
    check("t4_in_shift", {63'd0, obs_sen}, 64'd1);
    reset = 1'b1;
    #1;
    check("t4_rst_sen",  {63'd0, obs_sen}, 64'd0);
    check("t4_rst_ack",  {63'd0, obs_ack}, 64'd0);
    check("t4_rst_stb",  {63'd0, obs_stb}, 64'd0);
    check("t4_rst_cmt",  {63'd0, obs_cmt}, 64'd0);
    check("t4_rst_data", {32'd0, obs_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    load_a(32'h1234_5678);
    run_op(0, 1'b0);
    check("t4_nwords",  words.size(), 1);
    check("t4_word0",   words[0], 32'h1234_5678);
    check("t4_sen_cnt", sen_cnt, 32);
    check("t4_cmt_cyc", cmt_cyc, 35);

    // Request held high, commit acknowledged 5 cycles late
    load_a(32'h0BAD_F00D);
    run_op(5, 1'b1);
    check("t5_cmt_len", cmt_len, 6);
    check("t5_ack_cnt", ack_cnt, 1);
    check("t5_word0",   words[0], 32'h0BAD_F00D);
    check("t5_idle_no_ack", {63'd0, obs_ack}, 64'd0);
    @(negedge clk);
    check("t5_second_ack", {63'd0, obs_ack}, 64'd1);
    val = 1'b0;
    clear_rec();
    cyc = 1;
    wait_done(0);
    check("t5b_ack_cnt", ack_cnt, 1);
    check("t5b_cmt_cyc", cmt_cyc, 35);
    check("t5b_word0",   words[0], 32'h0);

    // Stray commit acknowledges in IDLE and during SHIFT
    cack = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_cmt", {63'd0, obs_cmt}, 64'd0);
    check("t6_idle_ack", {63'd0, obs_ack}, 64'd0);
    cack = 1'b0;
    load_a(32'h8000_0001);
    clear_rec();
    val = 1'b1;
    @(negedge clk); cyc = 1; val = 1'b0;
    repeat (4) begin @(negedge clk); cyc++; end
    cack = 1'b1;
    repeat (3) begin @(negedge clk); cyc++; end
    check("t6_shift_sen", {63'd0, obs_sen}, 64'd1);
    check("t6_shift_cmt", {63'd0, obs_cmt}, 64'd0);
    cack = 1'b0;
    wait_done(0);
    check("t6_cmt_cyc", cmt_cyc, 35);
    check("t6_word0",   words[0], 32'h8000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
